regfile_2r1w: RTL and testbench

- Parametrised successor to the team's single-port register file.
- Separate write port plus two independent read ports.
- Registered (1-cycle) reads, write-to-read bypass, and a reset-driven clear sequencer that zeroes every entry one per cycle.
- Sits in the datapath as the architectural register file feeding ALU operand latches.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/regfile_clear_seq.sv | 56 +++++
 rtl/regfile_2r1w.sv | 85 ++++++++
 tb/tb_regfile_2r1w.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the 2-read/1-write register file.
// The optional hardwired-zero entry is enabled by defining REGFILE_ZERO_REG_EN.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int ZERO_ADDR  = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Reset-driven clear sequencer: walks every entry once after reset, then
// reports the register file as ready.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  output logic              clear_we,
  output logic [ADDR_W-1:0] clear_addr,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  rf_state_e         state, state_next;
  logic [ADDR_W-1:0] clr_cnt, clr_cnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  // The counter parks on the last entry when leaving CLEAR, so it never wraps.
  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    clear_we     = 1'b0;
    init_done    = 1'b0;
    case (state)
      CLEAR: begin
        clear_we = 1'b1;
        if (clr_cnt == LAST_ADDR) begin
          state_next = READY;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
        end
      end
      READY: begin
        init_done = 1'b1;
      end
      default: begin
        state_next = CLEAR;
      end
    endcase
  end

  assign clear_addr = clr_cnt;

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with one write port, two registered read ports, write-first
// bypass and a clear-on-reset sequence. Define REGFILE_ZERO_REG_EN for a hardwired-zero entry 0.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2,
  output logic              rvalid,
  output logic              init_done
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              clear_we;
  logic [ADDR_W-1:0] clear_addr;
  logic              user_we;
  logic              user_re;
  logic [DATA_W-1:0] rd1_next, rd2_next;

  regfile_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk       (clk),
    .rst       (rst),
    .clear_we  (clear_we),
    .clear_addr(clear_addr),
    .init_done (init_done)
  );

  // User traffic is only honoured once the clear sequence has finished.
  assign user_re = re && init_done && !rst;
`ifdef REGFILE_ZERO_REG_EN
  assign user_we = we && init_done && !rst && (waddr != ADDR_W'(ZERO_ADDR));
`else
  assign user_we = we && init_done && !rst;
`endif

  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[clear_addr] <= '0;
    end else if (user_we) begin
      mem[waddr] <= wdata;
    end
  end

  // Write-first bypass per port; a hardwired zero entry overrides the bypass.
  always_comb begin
    rd1_next = mem[raddr1];
    rd2_next = mem[raddr2];
    if (we && (raddr1 == waddr)) rd1_next = wdata;
    if (we && (raddr2 == waddr)) rd2_next = wdata;
`ifdef REGFILE_ZERO_REG_EN
    if (raddr1 == ADDR_W'(ZERO_ADDR)) rd1_next = '0;
    if (raddr2 == ADDR_W'(ZERO_ADDR)) rd2_next = '0;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata1 <= '0;
      rdata2 <= '0;
      rvalid <= 1'b0;
    end else if (user_re) begin
      rdata1 <= rd1_next;
      rdata2 <= rd2_next;
      rvalid <= 1'b1;
    end else begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Self-checking bench for regfile_2r1w: directed scenarios plus random traffic
// compared every cycle against an array-based reference model.
module tb_regfile_2r1w;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        re;
  logic [4:0]  raddr1;
  logic [4:0]  raddr2;
  logic [31:0] rdata1;
  logic [31:0] rdata2;
  logic        rvalid;
  logic        init_done;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] refMem [32];
  int          refClrIdx;
  bit          refReady;
  logic [31:0] refRd1, refRd2;
  bit          refValid;

  regfile_2r1w #(
    .DATA_W(32),
    .ADDR_W(5)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re       (re),
    .raddr1   (raddr1),
    .raddr2   (raddr2),
    .rdata1   (rdata1),
    .rdata2   (rdata2),
    .rvalid   (rvalid),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: observed %h, expected %h (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  // Reference behaviour: reset restarts a 32-step clear, then writes land
  // before same-cycle reads (write-first), reads are captured or held.
  task automatic modelStep(input bit r, input bit w, input logic [4:0] wa,
                           input logic [31:0] wd, input bit rd,
                           input logic [4:0] a1, input logic [4:0] a2);
    if (r) begin
      refReady  = 1'b0;
      refClrIdx = 0;
      refValid  = 1'b0;
      refRd1    = '0;
      refRd2    = '0;
    end else if (!refReady) begin
      refMem[refClrIdx] = '0;
      refClrIdx++;
      if (refClrIdx == 32) refReady = 1'b1;
      refValid = 1'b0;
    end else begin
`ifdef REGFILE_ZERO_REG_EN
      if (w && wa != 5'd0) refMem[wa] = wd;
`else
      if (w) refMem[wa] = wd;
`endif
      if (rd) begin
        refRd1   = refMem[a1];
        refRd2   = refMem[a2];
        refValid = 1'b1;
      end else begin
        refValid = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input bit r, input bit w, input logic [4:0] wa,
                               input logic [31:0] wd, input bit rd,
                               input logic [4:0] a1, input logic [4:0] a2);
    rst = r; we = w; waddr = wa; wdata = wd; re = rd; raddr1 = a1; raddr2 = a2;
    @(posedge clk);
    modelStep(r, w, wa, wd, rd, a1, a2);
    #1;
    checkOutput("init_done", {31'd0, init_done}, {31'd0, refReady});
    checkOutput("rvalid", {31'd0, rvalid}, {31'd0, refValid});
    checkOutput("rdata1", rdata1, refRd1);
    checkOutput("rdata2", rdata2, refRd2);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic resetPulse();
    applyStimulus(1, 0, '0, '0, 0, '0, '0);
  endtask

  initial begin
    logic [4:0] a1, a2, wa;

    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; re = 1'b0; raddr1 = '0; raddr2 = '0;
    refReady = 1'b0; refClrIdx = 0; refValid = 1'b0; refRd1 = '0; refRd2 = '0;
    for (int i = 0; i < 32; i++) refMem[i] = 'x;
    #2;

    $display("[TB] initial reset and clear timing");
    resetPulse();
    checkOutput("reset_rvalid", {31'd0, rvalid}, 32'd0);
    idle(31);
    checkOutput("init_not_yet", {31'd0, init_done}, 32'd0);
    idle(1);
    checkOutput("init_at_32", {31'd0, init_done}, 32'd1);

    $display("[TB] preload then clear");
    for (int i = 0; i < 32; i++) applyStimulus(0, 1, 5'(i), 32'hDEADBEEF, 0, '0, '0);
    resetPulse();
    idle(32);
    for (int i = 0; i < 32; i += 2) begin
      applyStimulus(0, 0, '0, '0, 1, 5'(i), 5'(i + 1));
      checkOutput("cleared_p1", rdata1, 32'h0);
      checkOutput("cleared_p2", rdata2, 32'h0);
    end

    $display("[TB] basic write/read");
    applyStimulus(0, 1, 5'd7, 32'h12345678, 0, '0, '0);
    applyStimulus(0, 1, 5'd3, 32'h00000033, 1, 5'd7, 5'd7);
    checkOutput("basic_rd1", rdata1, 32'h12345678);
    checkOutput("basic_rd2", rdata2, 32'h12345678);
    checkOutput("basic_valid", {31'd0, rvalid}, 32'd1);

    $display("[TB] bypass");
    applyStimulus(0, 1, 5'd9, 32'hA5A5A5A5, 1, 5'd9, 5'd3);
    checkOutput("bypass_rd1", rdata1, 32'hA5A5A5A5);
    checkOutput("bypass_rd2", rdata2, 32'h00000033);
    applyStimulus(0, 1, 5'd12, 32'hCAFEF00D, 1, 5'd12, 5'd12);
    checkOutput("bypass_both", rdata2, 32'hCAFEF00D);

    $display("[TB] hold");
    applyStimulus(0, 0, '0, '0, 1, 5'd7, 5'd9);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 1, 5'd7, 32'h1, 0, 5'd7, 5'd7);
      checkOutput("hold_rd1", rdata1, 32'h12345678);
      checkOutput("hold_valid", {31'd0, rvalid}, 32'd0);
    end
    applyStimulus(0, 0, '0, '0, 1, 5'd7, 5'd7);
    checkOutput("after_hold", rdata1, 32'h1);

    $display("[TB] reset mid-clear");
    resetPulse();
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 5'(i + 16), 32'hFFFF0000, 1, 5'(i + 16), '0);
    resetPulse();
    for (int i = 0; i < 31; i++) applyStimulus(0, 1, 5'(i), 32'h0BAD0BAD, 1, 5'(i), '0);
    checkOutput("restart_not_yet", {31'd0, init_done}, 32'd0);
    idle(1);
    checkOutput("restart_init", {31'd0, init_done}, 32'd1);
    applyStimulus(0, 0, '0, '0, 1, 5'd16, 5'd25);
    checkOutput("no_trace_p1", rdata1, 32'h0);
    checkOutput("no_trace_p2", rdata2, 32'h0);

`ifdef REGFILE_ZERO_REG_EN
    $display("[TB] hardwired zero entry");
    applyStimulus(0, 1, 5'd0, 32'hFFFFFFFF, 1, 5'd0, 5'd0);
    checkOutput("zero_bypass", rdata1, 32'h0);
    applyStimulus(0, 0, '0, '0, 1, 5'd0, 5'd1);
    checkOutput("zero_later", rdata1, 32'h0);
`endif

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      a1 = ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      a2 = ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wa = ($urandom % 2) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      applyStimulus(($urandom % 200) == 0, ($urandom % 2) == 0, wa, $urandom,
                    ($urandom % 5) < 3, a1, a2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
